// File: rtl/keypad_if.sv
// Key event handshake between the keypad scanner and its consumer.
interface keypad_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;

   modport master (output key_valid, output key_code, input key_ready);
   modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, one event per accepted press.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 100000
) (
   input  logic       clk,
   input  logic       resetn,
   output logic [3:0] key_col,
   input  logic [3:0] key_row,
   keypad_if.master   kp,
   output logic       key_down,
   output logic       overflow
);

   localparam int unsigned SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DB_W   = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        sync1_q, rs_q;
   logic [1:0]        col_q, col_d;
   logic [1:0]        row_q, row_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [DB_W-1:0]   db_q, db_d;
   logic [3:0]        key_col_q, key_col_d;
   logic              valid_q, valid_d;
   logic [3:0]        code_q, code_d;
   logic              down_q, down_d;
   logic              ovf_q, ovf_d;
   logic [1:0]        low_row_c;

   // Lowest-index active row wins when several rows read low (no ghost resolution).
   always_comb begin
      low_row_c = 2'd3;
      if      (!rs_q[0]) low_row_c = 2'd0;
      else if (!rs_q[1]) low_row_c = 2'd1;
      else if (!rs_q[2]) low_row_c = 2'd2;
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      slot_d  = slot_q;
      db_d    = db_q;
      valid_d = valid_q;
      code_d  = code_q;
      down_d  = down_q;
      ovf_d   = ovf_q;

      if (valid_q && kp.key_ready) valid_d = 1'b0;

      case (state_q)
         SCAN: begin
            if (slot_q == SLOT_MAX) begin
               slot_d = '0;
               if (rs_q == 4'hF) begin
                  col_d = col_q + 2'd1;
               end else begin
                  row_d   = low_row_c;
                  db_d    = '0;
                  state_d = DEBOUNCE;
               end
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
         DEBOUNCE: begin
            if (rs_q[row_q]) begin
               state_d = SCAN;
               col_d   = col_q + 2'd1;
               slot_d  = '0;
            end else if (db_q == DB_MAX) begin
               state_d = HOLD;
               down_d  = 1'b1;
               // A still-pending event that is not being taken this cycle wins; the new press is lost.
               if (!valid_q || kp.key_ready) begin
                  code_d  = {row_q, col_q};
                  valid_d = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end else begin
               db_d = db_q + DB_W'(1);
            end
         end
         HOLD: begin
            if (rs_q[row_q]) begin
               db_d    = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!rs_q[row_q]) begin
               state_d = HOLD;
            end else if (db_q == DB_MAX) begin
               down_d  = 1'b0;
               state_d = SCAN;
               col_d   = col_q + 2'd1;
               slot_d  = '0;
            end else begin
               db_d = db_q + DB_W'(1);
            end
         end
         default: state_d = SCAN;
      endcase

      key_col_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= SCAN;
         sync1_q   <= 4'hF;
         rs_q      <= 4'hF;
         col_q     <= 2'd0;
         row_q     <= 2'd0;
         slot_q    <= '0;
         db_q      <= '0;
         key_col_q <= 4'hE;
         valid_q   <= 1'b0;
         code_q    <= 4'h0;
         down_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= key_row;
         rs_q      <= sync1_q;
         col_q     <= col_d;
         row_q     <= row_d;
         slot_q    <= slot_d;
         db_q      <= db_d;
         key_col_q <= key_col_d;
         valid_q   <= valid_d;
         code_q    <= code_d;
         down_q    <= down_d;
         ovf_q     <= ovf_d;
      end
   end

   assign key_col      = key_col_q;
   assign kp.key_valid = valid_q;
   assign kp.key_code  = code_q;
   assign key_down     = down_q;
   assign overflow     = ovf_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven during scanning (minimum 4).
REQ-002 Parameter DEBOUNCE_CNT, default 100000: consecutive stable row samples needed to accept a press or a release (minimum 2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 key_col  output  4  column drive, active-low, one-hot-low while scanning.
REQ-006 key_row  input  4  row sense, active-low (pulled up externally), asynchronous to clk.
REQ-007 key_valid  output  1  key_code holds an undelivered press event.
REQ-008 key_code  output  4  event code = row*4 + col.
REQ-009 key_ready  input  1  consumer accepts the event when key_valid && key_ready.
REQ-010 key_down  output  1  level: an accepted key is currently held.
REQ-011 overflow  output  1  sticky: a press was dropped; cleared only by reset.

Function
REQ-012 key_row shall pass through a 2-flop synchronizer; all logic below shall use only the synchronized value (rs).
REQ-013 The FSM shall have states SCAN, DEBOUNCE, HOLD and RELEASE.
REQ-014 SCAN: drive column c (key_col = ~(4'b1 << c)); a slot counter shall count 0..SCAN_DIV-1; rs shall be sampled only when the counter equals SCAN_DIV-1.
REQ-015 SCAN, sample with rs == 4'hF: c shall advance modulo 4 (3 wraps to 0), and the slot counter shall clear.
REQ-016 SCAN, sample with any rs bit low: latch c and r = the lowest-index low row bit, clear the debounce counter, go to DEBOUNCE, and keep driving column c.
REQ-017 DEBOUNCE: each cycle rs[r]==0 shall increment the counter; rs[r]==1 shall return to SCAN with c advanced.
REQ-018 DEBOUNCE: when the counter reaches DEBOUNCE_CNT-1 with rs[r]==0, go to HOLD and raise key_down on the next cycle.
REQ-019 On the DEBOUNCE->HOLD transition with key_valid==0, or with key_valid==1 && key_ready==1 in that same cycle: load key_code = {r[1:0], c[1:0]} and set key_valid on the next cycle.
REQ-020 On the DEBOUNCE->HOLD transition with key_valid==1 && key_ready==0: drop the new event, keep key_code unchanged, and set overflow.
REQ-021 key_valid shall clear the cycle after key_valid && key_ready, unless REQ-019 reloads it in that same cycle; key_code shall be stable while key_valid==1.
REQ-022 HOLD: keep column c; rs[r]==1 shall clear the counter and go to RELEASE.
REQ-023 RELEASE: rs[r]==1 for DEBOUNCE_CNT consecutive cycles shall drop key_down and go to SCAN with c advanced; rs[r]==0 shall return to HOLD.
REQ-024 Other keys pressed during DEBOUNCE/HOLD/RELEASE shall be ignored; ghosting is not resolved (lowest row wins).
REQ-025 Counters shall be sized with $clog2 of their maximum value and shall saturate rather than wrap.

Reset
REQ-026 While resetn==0, asynchronously force:
 - state = SCAN, c = 0, all counters = 0
 - key_col = 4'b1110
 - key_valid = 0, key_code = 0, key_down = 0, overflow = 0
 - synchronizer flops = 4'hF
REQ-027 Reset asserted mid-DEBOUNCE/HOLD shall discard the pending press; the first post-reset event requires a full new debounce.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-028 Idle, key_row=F for 64 cycles -> key_col cycles E,D,B,7,E each 4 cycles, key_valid stays 0.
REQ-029 Hold row 2 low while column 1 is driven, key_ready=1 -> key_code=9, key_valid high exactly 1 cycle, key_down=1 until 8 cycles after release.
REQ-030 Row bounce (low 3 cycles, high 1, repeat) -> no key_valid, scan resumes at next column.
REQ-031 key_ready=0, press key 0, release, then press key 5 -> key_code stays 0, overflow=1; raising key_ready -> key_valid drops, code 0 delivered once.
REQ-032 Rows 1 and 3 low simultaneously on column 2 -> key_code=6.
REQ-033 resetn pulsed low during HOLD with key_valid=1 -> all outputs at reset values immediately, key_col=E.
